// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: bidirectional PS/2 host controller for the keyboard port.
// Receives device frames, sends host command bytes, and arbitrates the
// shared open-drain clock/data pair so a frame in flight is never disturbed.
// Optional build macro PS2_RX_PARITY_CHECK_EN: when defined, a received
// parity mismatch is reported as rx_err instead of delivering the byte.
module ps2_host_ctrl #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cmd_valid,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_tx_done,
    output logic       o_tx_err,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_err,
    inout  wire        io_ps2_clk,
    inout  wire        io_ps2_dat
);

    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_INHIBIT,
        S_REQ,
        S_TX,
        S_ACK
    } state_t;

    state_t           r_state, w_stateNext;
    logic [2:0]       r_clkSync;
    logic [1:0]       r_datSync;
    logic [3:0]       r_bitCnt, w_bitCntNext;
    logic [CNT_W-1:0] r_cnt, w_cntNext;
    logic [7:0]       r_rxShift, w_rxShiftNext;
    logic             r_rxPar, w_rxParNext;
    logic [7:0]       r_txByte, w_txByteNext;
    logic             r_txPar, w_txParNext;
    logic             r_clkLow, w_clkLowNext;
    logic             r_datLow, w_datLowNext;
    logic [7:0]       r_rxData, w_rxDataNext;
    logic             r_rxValid, w_rxValidNext;
    logic             r_rxErr, w_rxErrNext;
    logic             r_txDone, w_txDoneNext;
    logic             r_txErr, w_txErrNext;
    logic             w_fe;
    logic             w_dat;
    logic             w_timeout;
    logic             w_parBad;

    // Open-drain pins: only ever pull low or let go.
    assign io_ps2_clk = r_clkLow ? 1'b0 : 1'bz;
    assign io_ps2_dat = r_datLow ? 1'b0 : 1'bz;

    assign w_fe      = r_clkSync[2] & ~r_clkSync[1];
    assign w_dat     = r_datSync[1];
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_parBad  = PAR_CHECK & ~(^{r_rxShift, r_rxPar});

    assign o_cmd_ready = (r_state == S_IDLE) && !w_fe;
    assign o_tx_done   = r_txDone;
    assign o_tx_err    = r_txErr;
    assign o_rx_valid  = r_rxValid;
    assign o_rx_data   = r_rxData;
    assign o_rx_err    = r_rxErr;

    // Bring the asynchronous bus lines into the clk domain; idle lines read high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clkSync <= 3'b111;
            r_datSync <= 2'b11;
        end else begin
            r_clkSync <= {r_clkSync[1:0], io_ps2_clk};
            r_datSync <= {r_datSync[0], io_ps2_dat};
        end
    end

    // State register plus all frame bookkeeping and registered status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bitCnt  <= '0;
            r_cnt     <= '0;
            r_rxShift <= '0;
            r_rxPar   <= 1'b0;
            r_txByte  <= '0;
            r_txPar   <= 1'b0;
            r_clkLow  <= 1'b0;
            r_datLow  <= 1'b0;
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
            r_rxErr   <= 1'b0;
            r_txDone  <= 1'b0;
            r_txErr   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_bitCnt  <= w_bitCntNext;
            r_cnt     <= w_cntNext;
            r_rxShift <= w_rxShiftNext;
            r_rxPar   <= w_rxParNext;
            r_txByte  <= w_txByteNext;
            r_txPar   <= w_txParNext;
            r_clkLow  <= w_clkLowNext;
            r_datLow  <= w_datLowNext;
            r_rxData  <= w_rxDataNext;
            r_rxValid <= w_rxValidNext;
            r_rxErr   <= w_rxErrNext;
            r_txDone  <= w_txDoneNext;
            r_txErr   <= w_txErrNext;
        end
    end

    // Next-state logic: a device start bit beats a command request in IDLE.
    always_comb begin
        w_stateNext   = r_state;
        w_bitCntNext  = r_bitCnt;
        w_cntNext     = r_cnt;
        w_rxShiftNext = r_rxShift;
        w_rxParNext   = r_rxPar;
        w_txByteNext  = r_txByte;
        w_txParNext   = r_txPar;
        w_clkLowNext  = r_clkLow;
        w_datLowNext  = r_datLow;
        w_rxDataNext  = r_rxData;
        w_rxValidNext = 1'b0;
        w_rxErrNext   = 1'b0;
        w_txDoneNext  = 1'b0;
        w_txErrNext   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bitCntNext = '0;
                w_cntNext    = '0;
                w_clkLowNext = 1'b0;
                w_datLowNext = 1'b0;
                if (w_fe) begin
                    if (!w_dat) w_stateNext = S_RX;
                end else if (i_cmd_valid) begin
                    w_stateNext  = S_INHIBIT;
                    w_txByteNext = i_cmd_data;
                    w_txParNext  = ~^i_cmd_data;
                    w_clkLowNext = 1'b1;
                end
            end
            S_RX: begin
                if (w_fe) begin
                    w_cntNext    = '0;
                    w_bitCntNext = r_bitCnt + 4'd1;
                    if (r_bitCnt < 4'd8) begin
                        w_rxShiftNext = {w_dat, r_rxShift[7:1]};
                    end else if (r_bitCnt == 4'd8) begin
                        w_rxParNext = w_dat;
                    end else begin
                        w_stateNext = S_IDLE;
                        if (!w_dat || w_parBad) begin
                            w_rxErrNext = 1'b1;
                        end else begin
                            w_rxValidNext = 1'b1;
                            w_rxDataNext  = r_rxShift;
                        end
                    end
                end else if (w_timeout) begin
                    w_stateNext = S_IDLE;
                    w_rxErrNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            S_INHIBIT: begin
                if (r_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                    w_stateNext  = S_REQ;
                    w_cntNext    = '0;
                    w_clkLowNext = 1'b0;
                    w_datLowNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            S_REQ: begin
                w_stateNext = S_TX;
                w_cntNext   = r_cnt + CNT_W'(1);
            end
            S_TX, S_ACK: begin
                if (w_fe) begin
                    w_cntNext    = '0;
                    w_bitCntNext = r_bitCnt + 4'd1;
                    if (r_state == S_ACK) begin
                        w_stateNext  = S_IDLE;
                        w_txDoneNext = !w_dat;
                        w_txErrNext  = w_dat;
                    end else if (r_bitCnt < 4'd8) begin
                        w_datLowNext = ~r_txByte[r_bitCnt[2:0]];
                    end else if (r_bitCnt == 4'd8) begin
                        w_datLowNext = ~r_txPar;
                    end else begin
                        w_datLowNext = 1'b0;
                        w_stateNext  = S_ACK;
                    end
                end else if (w_timeout) begin
                    w_stateNext  = S_IDLE;
                    w_clkLowNext = 1'b0;
                    w_datLowNext = 1'b0;
                    w_txErrNext  = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext  = S_IDLE;
                w_clkLowNext = 1'b0;
                w_datLowNext = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: randomized bench for ps2_host_ctrl with a behavioural
// PS/2 keyboard model on the open-drain pins and a frame-level reference.
module tb_ps2_host_ctrl;

    localparam int INHIBIT = 40;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 10;

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmdValid;
    logic [7:0] cmdData;
    logic       cmdReady, txDone, txErr, rxValid, rxErr;
    logic [7:0] rxData;
    logic       devClkLow, devDatLow;
    wire        ps2Clk, ps2Dat;

    assign ps2Clk = devClkLow ? 1'b0 : 1'bz;
    assign ps2Dat = devDatLow ? 1'b0 : 1'bz;
    pullup (ps2Clk);
    pullup (ps2Dat);

    ps2_host_ctrl #(.INHIBIT_CYC(INHIBIT), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_cmd_valid(cmdValid),
        .i_cmd_data (cmdData),
        .o_cmd_ready(cmdReady),
        .o_tx_done  (txDone),
        .o_tx_err   (txErr),
        .o_rx_valid (rxValid),
        .o_rx_data  (rxData),
        .o_rx_err   (rxErr),
        .io_ps2_clk (ps2Clk),
        .io_ps2_dat (ps2Dat)
    );

    always #5 clk = ~clk;

    int         assertCount = 0;
    int         failCount   = 0;
    int         cycle       = 0;
    int         nRxValid = 0, nRxErr = 0, nTxDone = 0, nTxErr = 0, nOverlap = 0;
    int         lastFallCycle = 0;
    int         acceptCycle   = 0;
    int         curRxBit      = -1;
    logic [7:0] expRxData     = 8'h00;

    // Count status pulses and flag any cycle with two of them at once.
    always @(negedge clk) begin
        cycle++;
        if (rxValid) nRxValid++;
        if (rxErr)   nRxErr++;
        if (txDone)  nTxDone++;
        if (txErr)   nTxErr++;
        if ((int'(rxValid) + int'(rxErr) + int'(txDone) + int'(txErr)) > 1) nOverlap++;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Odd parity bit for a byte, by counting ones.
    function automatic logic oddPar(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0);
    endfunction

    // Device-to-host frame: data set while clock high, host samples on fall.
    task automatic devSendFrame(input logic [7:0] d, input logic par, input logic stop, input int nBits);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            curRxBit  = i;
            devDatLow = ~bits[i];
            waitCycles(3);
            devClkLow     = 1'b1;
            lastFallCycle = cycle;
            waitCycles(HALF);
            devClkLow = 1'b0;
            waitCycles(HALF);
        end
        devDatLow = 1'b0;
        curRxBit  = 99;
    endtask

    // Host-to-device frame as seen by the keyboard: inhibit, request, 11 clocks.
    task automatic devReceiveCmd(input logic ackLow, input logic checkInhibit,
                                 output logic [7:0] gotByte, output logic gotPar, output logic gotStop);
        int guard;
        int lowCnt;
        gotByte = 8'h00;
        gotPar  = 1'b0;
        gotStop = 1'b0;
        guard   = 0;
        while (ps2Clk !== 1'b0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("host pulls clk low", ps2Clk, 0);
        lowCnt = 0;
        while (ps2Clk === 1'b0 && lowCnt < 4000) begin
            @(negedge clk);
            lowCnt++;
        end
        if (checkInhibit) checkOutput("inhibit length", lowCnt, INHIBIT);
        checkOutput("request start bit", ps2Dat, 0);
        waitCycles(3);
        for (int i = 1; i <= 11; i++) begin
            devClkLow = 1'b1;
            waitCycles(HALF);
            devClkLow = 1'b0;
            if (i <= 8)       gotByte[i-1] = ps2Dat;
            else if (i == 9)  gotPar  = ps2Dat;
            else if (i == 10) gotStop = ps2Dat;
            waitCycles(HALF);
            if (i == 10) devDatLow = ackLow;
        end
        devDatLow = 1'b0;
    endtask

    // Present a command until the host takes it (or give up).
    task automatic issueCmd(input logic [7:0] d, output logic accepted);
        accepted = 1'b0;
        cmdData  = d;
        cmdValid = 1'b1;
        for (int k = 0; k < 2000 && !accepted; k++) begin
            if (cmdReady) begin
                accepted    = 1'b1;
                acceptCycle = cycle;
            end
            @(negedge clk);
        end
        cmdValid = 1'b0;
    endtask

    // One receive frame checked against the frame-level rules.
    task automatic runRx(input logic [7:0] d, input logic par, input logic stop);
        int   v0, e0;
        logic parOk, expValid;
        v0 = nRxValid;
        e0 = nRxErr;
        parOk    = (par == oddPar(d));
        expValid = stop && (parOk || !PAR_CHECK);
        devSendFrame(d, par, stop, 11);
        waitCycles(8);
        if (expValid) expRxData = d;
        checkOutput("rx_valid pulses", nRxValid - v0, expValid ? 1 : 0);
        checkOutput("rx_err pulses", nRxErr - e0, expValid ? 0 : 1);
        checkOutput("rx_data", rxData, expRxData);
        checkOutput("cmd_ready after rx", cmdReady, 1);
    endtask

    // One command transmission with the keyboard acking or not.
    task automatic runTx(input logic [7:0] d, input logic ackLow);
        int   d0, e0;
        logic acc, gotPar, gotStop;
        logic [7:0] gotByte;
        d0 = nTxDone;
        e0 = nTxErr;
        fork
            issueCmd(d, acc);
            devReceiveCmd(ackLow, 1'b1, gotByte, gotPar, gotStop);
        join
        waitCycles(8);
        checkOutput("cmd accepted", acc, 1);
        checkOutput("tx byte on wire", gotByte, d);
        checkOutput("tx parity on wire", gotPar, oddPar(d));
        checkOutput("tx stop released", gotStop, 1);
        checkOutput("tx_done pulses", nTxDone - d0, ackLow ? 1 : 0);
        checkOutput("tx_err pulses", nTxErr - e0, ackLow ? 0 : 1);
        checkOutput("cmd_ready after tx", cmdReady, 1);
    endtask

    // Random mix of receive, corrupted receive and transmit frames.
    task automatic applyStimulus(input int n);
        int         kind;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 3));
            d    = 8'($urandom);
            case (kind)
                0:       runRx(d, oddPar(d), 1'b1);
                1:       runRx(d, 1'($urandom), 1'b1);
                2:       runRx(d, oddPar(d), 1'b0);
                default: runTx(d, 1'($urandom));
            endcase
            waitCycles(5);
        end
    endtask

    initial begin
        logic       acc, gotPar, gotStop;
        logic [7:0] gotByte;
        int         v0, e0, t0, guard, delta;

        reset     = 1'b0;
        cmdValid  = 1'b0;
        cmdData   = 8'h00;
        devClkLow = 1'b0;
        devDatLow = 1'b0;
        waitCycles(3);
        checkOutput("reset rx_data", rxData, 8'h00);
        checkOutput("reset pulses", {rxValid, rxErr, txDone, txErr}, 4'b0000);
        checkOutput("reset lines released", {ps2Clk, ps2Dat}, 2'b11);
        reset = 1'b1;
        waitCycles(2);
        checkOutput("cmd_ready after reset", cmdReady, 1);

        // Directed frames from the plan.
        runRx(8'h1C, 1'b0, 1'b1);
        runRx(8'h1C, 1'b1, 1'b1);
        runTx(8'hED, 1'b1);
        runTx(8'hFF, 1'b0);

        // A clock pulse with data high is not a start bit.
        v0 = nRxValid;
        e0 = nRxErr;
        devClkLow = 1'b1;
        waitCycles(HALF);
        devClkLow = 1'b0;
        waitCycles(HALF);
        checkOutput("start bit 1 ignored", (nRxValid - v0) + (nRxErr - e0), 0);
        checkOutput("idle after ignored start", cmdReady, 1);

        // Command raised mid-frame waits for the frame to finish.
        v0 = nRxValid;
        t0 = nTxDone;
        curRxBit = -1;
        fork
            begin
                devSendFrame(8'h45, oddPar(8'h45), 1'b1, 11);
                devReceiveCmd(1'b1, 1'b0, gotByte, gotPar, gotStop);
            end
            begin
                guard = 0;
                while (curRxBit < 5 && guard < 2000) begin
                    @(negedge clk);
                    guard++;
                end
                waitCycles(2);
                checkOutput("cmd_ready low during rx", cmdReady, 0);
                issueCmd(8'hED, acc);
            end
        join
        waitCycles(8);
        expRxData = 8'h45;
        checkOutput("contended rx_valid", nRxValid - v0, 1);
        checkOutput("contended rx_data", rxData, 8'h45);
        checkOutput("inhibit after frame", acceptCycle > lastFallCycle, 1);
        checkOutput("contended cmd accepted", acc, 1);
        checkOutput("contended tx byte", gotByte, 8'hED);
        checkOutput("contended tx_done", nTxDone - t0, 1);

        // Device stops clocking after four bits.
        e0 = nRxErr;
        devSendFrame(8'h5A, 1'b0, 1'b1, 4);
        guard = 0;
        while (nRxErr == e0 && guard < TIMEOUT + 100) begin
            @(negedge clk);
            guard++;
        end
        delta = cycle - lastFallCycle;
        checkOutput("rx timeout err", nRxErr - e0, 1);
        checkOutput("rx timeout latency", (delta >= TIMEOUT + 1) && (delta <= TIMEOUT + 5), 1);
        checkOutput("idle after timeout", cmdReady, 1);
        checkOutput("rx_data kept after timeout", rxData, expRxData);

        // Reset in the middle of a transmit.
        fork
            issueCmd(8'h55, acc);
            waitCycles(INHIBIT + 6);
        join
        checkOutput("tx start bit driven", ps2Dat, 0);
        reset = 1'b0;
        waitCycles(2);
        expRxData = 8'h00;
        checkOutput("mid-tx reset lines", {ps2Clk, ps2Dat}, 2'b11);
        checkOutput("mid-tx reset rx_data", rxData, 8'h00);
        checkOutput("mid-tx reset pulses", {rxValid, rxErr, txDone, txErr}, 4'b0000);
        reset = 1'b1;
        waitCycles(2);
        checkOutput("cmd_ready after mid-tx reset", cmdReady, 1);
        checkOutput("lines released after reset", {ps2Clk, ps2Dat}, 2'b11);

        applyStimulus(24);

        checkOutput("overlapping pulses", nOverlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

Bidirectional PS/2 host controller that owns the keyboard's open-drain clock and data lines, sequencing device-to-host reception and host-to-device command transmission such as 0xED (set LEDs) and 0xFF (reset). It sits between the board PS/2 pins and the scan-code decode logic. It arbitrates the shared two-wire bus so that an in-flight receive frame is never corrupted by a command request, and it reports completion or error for every frame.

## Interface
- INHIBIT_CYC, 5000: clk cycles the clock line is held low before a transmit (100 µs at 50 MHz).
- TIMEOUT_CYC, 1000000: maximum clk cycles between device clock falling edges inside a frame (20 ms at 50 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  host command byte request.
- cmd_data  in  8  command byte, sampled on acceptance.
- cmd_ready  out  1  command can be accepted this cycle.
- tx_done  out  1  one-cycle pulse: device acknowledged the command.
- tx_err  out  1  one-cycle pulse: NACK or timeout during transmit.
- rx_valid  out  1  one-cycle pulse: rx_data holds a good byte.
- rx_data  out  8  last received byte, held until the next rx_valid.
- rx_err  out  1  one-cycle pulse: framing, parity or timeout error on receive.
- ps2_clk  inout  1  open-drain: driven 0 or released (z), never driven 1.
- ps2_dat  inout  1  open-drain, same rule.

## Operation
- Synchronisation: ps2_clk passes through a 3-flop synchroniser. A falling edge (fe) is sync stage 1 low while stage 2 is high. ps2_dat is sampled through 2 flops.
- States and transitions:
  - IDLE → RX: on fe with sampled data 0 (start bit).
  - IDLE → INHIBIT: on cmd_valid && cmd_ready; latch cmd_data and odd parity ~^cmd_data.
  - RX → IDLE: after the 11th bit, or on timeout.
  - INHIBIT: drive ps2_clk low for INHIBIT_CYC cycles → REQ.
  - REQ: drive ps2_dat low, release ps2_clk → TX.
  - TX: on fe 1..8 drive data bit 0..7 (LSB first); on fe 9 drive parity; on fe 10 release data (stop) → ACK.
  - ACK: on next fe sample data; 0 gives tx_done, 1 gives tx_err; → IDLE.
- cmd_ready = (state == IDLE) && !fe. A receive start in the same cycle as cmd_valid wins, and the command waits.
- RX frame: start(0), 8 data bits LSB first, odd parity, stop(1).
  - Start bit 1 at IDLE: ignored, stay IDLE.
  - Stop bit 0: rx_err.
- A data bit drives 0 by enabling the pull-down; a data bit 1 releases the line.
- Timeout: a counter resets on every fe and runs in RX, REQ, TX and ACK. On reaching TIMEOUT_CYC:
  - RX aborts with rx_err.
  - REQ, TX and ACK abort with tx_err.
  - All lines are released and the state returns to IDLE.
- Reset (any time, including mid-frame):
  - State → IDLE; both lines released; bit counter and timeout counter cleared.
  - rx_data = 0x00; tx_done, tx_err, rx_valid, rx_err = 0.
  - cmd_ready = 1 after reset deasserts.

## Timing
- rx_valid or rx_err asserts the cycle after the stop-bit fe is registered, which is 3 clk after the pin falls (sync latency).
- tx_done or tx_err asserts the cycle after the ACK fe is registered.
- Acceptance to ps2_clk driven low: 1 cycle. ps2_clk is released exactly INHIBIT_CYC cycles later, with ps2_dat driven low in the same cycle.
- TX data changes in the cycle after the fe is registered, well inside the device's clock-low half period.
- At most one status pulse per frame. Pulses never overlap.
- cmd_valid held during a non-IDLE state is not accepted and is not lost. cmd_data must be held stable until cmd_ready.

## Configuration
- PS2_RX_PARITY_CHECK_EN
  - Defined: a received parity mismatch gives rx_err, no rx_valid, and rx_data is unchanged.
  - Undefined: the parity bit is clocked in but ignored, and the byte is delivered with rx_valid.
- Stop-bit and timeout checks apply in both builds.

## Test plan
- Device sends 0x1C, parity 0, stop 1 → rx_valid one pulse, rx_data = 0x1C, no rx_err.
- Device sends 0x1C with parity 1 → macro defined: rx_err, rx_data keeps the prior value; macro undefined: rx_valid with 0x1C.
- cmd 0xED; bench model: clk low ≥ INHIBIT_CYC, then drives 11 clocks and pulls data low at bit 11 → observed bits 1,0,1,1,0,1,1,1, parity 1, stop released, tx_done pulse.
- cmd 0xFF; device leaves data high at ACK → tx_err pulse, state IDLE, cmd_ready = 1.
- cmd_valid raised during the 5th bit of an incoming 0x45 → 0x45 received intact with rx_valid; INHIBIT starts only after the frame.
- Device stops clocking after 4 RX bits → rx_err exactly TIMEOUT_CYC cycles after the last fe. Reset pulsed mid-TX → both lines released, all outputs at reset values.
